// File: rtl/dpram_pkg.sv
// Shared constants for the dual-port sample-buffer RAM.
// Build option DPRAM_BYPASS_EN is consumed by dual_port_ram_16x8.
package dpram_pkg;

    localparam int unsigned DATA_W_DEF   = 8;
    localparam int unsigned ADDR_W_DEF   = 4;
    localparam logic        RESET_ACTIVE = 1'b0;

endpackage : dpram_pkg

// File: rtl/dual_port_ram_16x8.sv
// Two-port RAM for ping-pong sample buffering: port A write-only, port B read/write.
// Define DPRAM_BYPASS_EN for write-first forwarding on a same-address port-A write / port-B read.
module dual_port_ram_16x8
    import dpram_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              we_wr_port,
    input  logic [ADDR_W-1:0] addr_wr_port,
    output logic [DATA_W-1:0] out_data,
    input  logic              we_rd_port,
    input  logic [ADDR_W-1:0] addr_rd_port
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    // Kept under this exact name so benches can inspect contents hierarchically.
    logic [DATA_W-1:0] mem [DEPTH];

    logic w_same_addr;
    assign w_same_addr = (addr_wr_port == addr_rd_port);

    // Port B write is issued first so a same-address port A write lands last.
    always_ff @(posedge clk or negedge reset) begin
        if (reset == RESET_ACTIVE) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[ADDR_W'(i)] <= '0;
            end
            out_data <= '0;
        end else begin
            if (we_rd_port) begin
                mem[addr_rd_port] <= in_data;
            end
            if (we_wr_port) begin
                mem[addr_wr_port] <= in_data;
            end
            if (!we_rd_port) begin
`ifdef DPRAM_BYPASS_EN
                if (we_wr_port && w_same_addr) begin
                    out_data <= in_data;
                end else begin
                    out_data <= mem[addr_rd_port];
                end
`else
                out_data <= mem[addr_rd_port];
`endif
            end
        end
    end

`ifndef DPRAM_BYPASS_EN
    logic w_unused;
    assign w_unused = w_same_addr;
`endif

endmodule : dual_port_ram_16x8

// File: tb/tb_dual_port_ram_16x8.sv
// Scoreboard bench for dual_port_ram_16x8: stimulus queues the expected out_data
// for each clocked cycle; a monitor pops and compares just after the edge.
module tb_dual_port_ram_16x8;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       we_wr_port;
    logic [3:0] addr_wr_port;
    logic [7:0] out_data;
    logic       we_rd_port;
    logic [3:0] addr_rd_port;

    int checks   = 0;
    int failures = 0;

    logic [7:0] sb_q [$];
    string      name_q [$];
    logic [7:0] exp_mem [16];

    dual_port_ram_16x8 dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .we_wr_port   (we_wr_port),
        .addr_wr_port (addr_wr_port),
        .out_data     (out_data),
        .we_rd_port   (we_rd_port),
        .addr_rd_port (addr_rd_port)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Monitor: every edge with a queued expectation is checked 1 time unit later.
    always begin
        logic [7:0] e;
        string      n;
        @(posedge clk);
        if (sb_q.size() != 0) begin
            e = sb_q.pop_front();
            n = name_q.pop_front();
            #1;
            checks++;
            if (out_data !== e) begin
                failures++;
                $display("FAIL %s: out_data=%h expected=%h", n, out_data, e);
            end
        end
    end

    task automatic check(input string n, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", n, act, exp);
        end
    endtask

    // One clocked cycle: drive at negedge, queue the out_data expected after the next rising edge.
    task automatic cyc(input logic wa, input logic [3:0] aa, input logic wb,
                       input logic [3:0] ab, input logic [7:0] d,
                       input logic [7:0] exp, input string n);
        @(negedge clk);
        we_wr_port   = wa;
        addr_wr_port = aa;
        we_rd_port   = wb;
        addr_rd_port = ab;
        in_data      = d;
        sb_q.push_back(exp);
        name_q.push_back(n);
    endtask

    task automatic check_mem(input string n);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("%s[%0d]", n, i), dut.mem[i], exp_mem[i]);
        end
    endtask

    initial begin
        logic [7:0] col_exp;
        reset        = 1'b0;
        in_data      = 8'h00;
        we_wr_port   = 1'b0;
        addr_wr_port = 4'd0;
        we_rd_port   = 1'b0;
        addr_rd_port = 4'd0;
        for (int i = 0; i < 16; i++) exp_mem[i] = 8'h00;

        repeat (3) @(posedge clk);
        #1;
        check("reset_out", out_data, 8'h00);
        @(negedge clk);
        reset = 1'b1;
        check_mem("reset_mem");

        // mid-run reset after writing mem[3]
        cyc(1'b1, 4'd3, 1'b0, 4'd0, 8'hA5, 8'h00, "wr3_rd0");
        cyc(1'b0, 4'd0, 1'b0, 4'd3, 8'h00, 8'hA5, "rd3");
        @(negedge clk);
        we_wr_port   = 1'b1;
        addr_wr_port = 4'd4;
        in_data      = 8'hFF;
        #2;
        reset = 1'b0;
        #1;
        check("async_reset_out", out_data, 8'h00);
        @(posedge clk);
        @(negedge clk);
        we_wr_port = 1'b0;
        reset      = 1'b1;
        check_mem("post_reset_mem");

        // fill via port A while port B reads addr 0 (read-first on i=0)
        for (int i = 0; i < 16; i++) begin
            cyc(1'b1, 4'(i), 1'b0, 4'd0, 8'(8'h10 + i), (i == 0) ? 8'h00 : 8'h10,
                $sformatf("fill%0d", i));
            exp_mem[i] = 8'(8'h10 + i);
        end
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 4'd0, 1'b0, 4'(i), 8'h00, 8'(8'h10 + i), $sformatf("readback%0d", i));
        end

        // port B write holds out_data
        cyc(1'b0, 4'd0, 1'b1, 4'd7, 8'h3C, 8'h1F, "portb_wr_hold");
        exp_mem[7] = 8'h3C;
        cyc(1'b0, 4'd0, 1'b0, 4'd7, 8'h00, 8'h3C, "portb_wr_read7");

        // same-address read during write
        cyc(1'b1, 4'd5, 1'b0, 4'd7, 8'h11, 8'h3C, "set5");
`ifdef DPRAM_BYPASS_EN
        col_exp = 8'h22;
`else
        col_exp = 8'h11;
`endif
        cyc(1'b1, 4'd5, 1'b0, 4'd5, 8'h22, col_exp, "collision5");
        exp_mem[5] = 8'h22;
        cyc(1'b0, 4'd0, 1'b0, 4'd5, 8'h00, 8'h22, "after_collision5");

        // double writes, same then different addresses
        cyc(1'b1, 4'd9, 1'b1, 4'd9, 8'h5A, 8'h22, "dbl_same_hold");
        cyc(1'b0, 4'd0, 1'b0, 4'd9, 8'h00, 8'h5A, "dbl_same_read9");
        cyc(1'b1, 4'd9, 1'b1, 4'd10, 8'h6B, 8'h5A, "dbl_diff_hold");
        exp_mem[9]  = 8'h6B;
        exp_mem[10] = 8'h6B;
        cyc(1'b0, 4'd0, 1'b0, 4'd10, 8'h00, 8'h6B, "dbl_diff_read10");

        // idle: no enables, addresses and data toggling
        cyc(1'b0, 4'd3, 1'b0, 4'd1, 8'hEE, 8'h11, "idle_rd1");
        cyc(1'b0, 4'd12, 1'b0, 4'd2, 8'h77, 8'h12, "idle_rd2");
        cyc(1'b0, 4'd0, 1'b0, 4'd9, 8'h99, 8'h6B, "idle_rd9");
        cyc(1'b0, 4'd15, 1'b0, 4'd15, 8'h01, 8'h1F, "idle_rd15");

        @(negedge clk);
        addr_wr_port = 4'd0;
        addr_rd_port = 4'd0;
        @(posedge clk);
        #3;
        check_mem("final_mem");
        checks++;
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: pending=%0d expected=0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_dual_port_ram_16x8
